// File: rtl/addsub_pkg.sv
// Shared constants for the add/sub result stage: datapath width, flag layout
// and the signed-overflow rule used by the flag generator.
package addsub_pkg;

   localparam int ADDSUB_WIDTH = 5;
   localparam int FLAGS_W      = 4;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [FLAGS_W-1:0] flags_t;

   // b_msb is the operand bit before the unit inverts it for subtraction.
   function automatic logic signed_overflow(input logic sub,
                                            input logic a_msb,
                                            input logic b_msb,
                                            input logic s_msb);
      logic same_sign;
      same_sign = sub ? (a_msb != b_msb) : (a_msb == b_msb);
      return same_sign && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/addsub_flag_gen.sv
// Combinational N/Z/C/V flag generator for one add/sub result.
// Optional signed saturation of the stored value under ADDSUB_RESULT_SAT_EN.
module addsub_flag_gen
   import addsub_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH
) (
   input  logic             in_sub,
   input  logic             a_msb,
   input  logic             b_msb,
   input  logic [WIDTH-1:0] in_s,
   input  logic             in_c,
   output logic [WIDTH-1:0] st_s,
   output flags_t           st_flags
);

   logic v_raw;

   always_comb begin
      v_raw = signed_overflow(in_sub, a_msb, b_msb, in_s[WIDTH-1]);
      st_s  = in_s;
`ifdef ADDSUB_RESULT_SAT_EN
      // V and C describe the raw operation; only N and Z see the clamped value.
      if (v_raw) begin
         st_s = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      st_flags         = '0;
      st_flags[FLAG_N] = st_s[WIDTH-1];
      st_flags[FLAG_Z] = (st_s == '0);
      st_flags[FLAG_C] = in_c;
      st_flags[FLAG_V] = v_raw;
   end

endmodule

// File: rtl/addsub_result_stage.sv
// Registered 2-entry result FIFO with flag generation behind the add/sub unit.
// Build option: ADDSUB_RESULT_SAT_EN enables signed saturation of stored results.
module addsub_result_stage
   import addsub_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sub,
   input  logic             in_a_msb,
   input  logic             in_b_msb,
   input  logic [WIDTH-1:0] in_s,
   input  logic             in_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output flags_t           out_flags,
   output logic [1:0]       count
);

   // Handshakes: a beat transfers on a rising edge where valid && ready; the
   // sender holds its data stable until then. in_ready depends only on
   // occupancy, so a full stage refuses input even while it is being drained.
   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   logic [WIDTH-1:0] mem_s_q [DEPTH];
   logic [WIDTH-1:0] mem_s_d [DEPTH];
   flags_t           mem_f_q [DEPTH];
   flags_t           mem_f_d [DEPTH];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   logic [WIDTH-1:0] st_s;
   flags_t           st_flags;
   logic             push, pop;

   addsub_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .in_sub   (in_sub),
      .a_msb    (in_a_msb),
      .b_msb    (in_b_msb),
      .in_s     (in_s),
      .in_c     (in_c),
      .st_s     (st_s),
      .st_flags (st_flags)
   );

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != 2'd0);
   assign out_s     = mem_s_q[rd_ptr_q];
   assign out_flags = mem_f_q[rd_ptr_q];
   assign count     = count_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      mem_s_d  = mem_s_q;
      mem_f_d  = mem_f_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_s_d[wr_ptr_q] = st_s;
         mem_f_d[wr_ptr_q] = st_flags;
         wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_s_q[i] <= '0;
            mem_f_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_s_q  <= mem_s_d;
         mem_f_q  <= mem_f_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed testbench for addsub_result_stage: reset, flag vectors, back-pressure,
// simultaneous push/pop and reset with a full buffer.
module tb_addsub_result_stage;

   logic       clk;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic       in_sub;
   logic       in_a_msb;
   logic       in_b_msb;
   logic [4:0] in_s;
   logic       in_c;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_s;
   logic [3:0] out_flags;
   logic [1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] exp_q[$];

   addsub_result_stage dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sub    (in_sub),
      .in_a_msb  (in_a_msb),
      .in_b_msb  (in_b_msb),
      .in_s      (in_s),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_flags (out_flags),
      .count     (count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_inputs(input logic sub, input logic a, input logic b,
                             input logic [4:0] s, input logic c);
      in_sub   = sub;
      in_a_msb = a;
      in_b_msb = b;
      in_s     = s;
      in_c     = c;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_inputs(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_s !== 5'd0) begin n_fail++; $display("FAIL reset_out_s: got %b want 00000", out_s); end
      n_checks++; if (out_flags !== 4'd0) begin n_fail++; $display("FAIL reset_out_flags: got %b want 0000", out_flags); end
   endtask

   task automatic test_latency();
      logic [4:0] exp_s;
      logic [3:0] exp_f;
`ifdef ADDSUB_RESULT_SAT_EN
      exp_s = 5'b01111; exp_f = 4'b0001;
`else
      exp_s = 5'b10000; exp_f = 4'b1001;
`endif
      step();
      out_ready = 1'b1;
      set_inputs(1'b0, 1'b0, 1'b0, 5'b10000, 1'b0);
      in_valid = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: out_valid got %b want 0", out_valid); end
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_ovf_valid: got %b want 1", out_valid); end
      n_checks++; if (out_s !== exp_s) begin n_fail++; $display("FAIL add_ovf_s: got %b want %b", out_s, exp_s); end
      n_checks++; if (out_flags !== exp_f) begin n_fail++; $display("FAIL add_ovf_flags: got %b want %b", out_flags, exp_f); end
      step();
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL add_ovf_drain: count got %0d want 0", count); end
   endtask

   typedef struct packed {
      logic       sub;
      logic       a;
      logic       b;
      logic [4:0] s;
      logic       c;
      logic [4:0] exp_s;
      logic [3:0] exp_f;
   } vec_t;

   task automatic test_flags();
      vec_t vecs[7];
      // sub a  b  s          c     exp_s     exp_f
      vecs[1] = '{1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 4'b0110}; // 3-3
      vecs[4] = '{1'b0, 1'b0, 1'b1, 5'b00000, 1'b1, 5'b00000, 4'b0110}; // 5+(-5)
      vecs[5] = '{1'b1, 1'b1, 1'b0, 5'b11110, 1'b1, 5'b11110, 4'b1010}; // -1-1
      vecs[6] = '{1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 5'b11111, 4'b1000}; // 2-3, borrow
`ifdef ADDSUB_RESULT_SAT_EN
      vecs[0] = '{1'b0, 1'b0, 1'b0, 5'b10000, 1'b0, 5'b01111, 4'b0001}; // 7+9
      vecs[2] = '{1'b1, 1'b0, 1'b1, 5'b10111, 1'b0, 5'b01111, 4'b0001}; // 7-(-16)
      vecs[3] = '{1'b0, 1'b1, 1'b1, 5'b01111, 1'b1, 5'b10000, 4'b1011}; // -16+(-1)
`else
      vecs[0] = '{1'b0, 1'b0, 1'b0, 5'b10000, 1'b0, 5'b10000, 4'b1001};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 5'b10111, 1'b0, 5'b10111, 4'b1001};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 5'b01111, 1'b1, 5'b01111, 4'b0011};
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         set_inputs(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec%0d_valid: got %b want 1", i, out_valid); end
         n_checks++; if (out_s !== vecs[i].exp_s) begin n_fail++; $display("FAIL vec%0d_s: got %b want %b", i, out_s, vecs[i].exp_s); end
         n_checks++; if (out_flags !== vecs[i].exp_f) begin n_fail++; $display("FAIL vec%0d_flags: got %b want %b", i, out_flags, vecs[i].exp_f); end
         step();
         n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL vec%0d_drain: count got %0d want 0", i, count); end
      end
   endtask

   task automatic test_back_pressure();
      logic [4:0] exp_s;
      out_ready = 1'b0;
      exp_q.delete();
      set_inputs(1'b0, 1'b0, 1'b0, 5'd1, 1'b0);
      in_valid = 1'b1;
      step(); exp_q.push_back(5'd1);
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL bp_count1: got %0d want 1", count); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
      in_s = 5'd2;
      step(); exp_q.push_back(5'd2);
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL bp_count2: got %0d want 2", count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
      in_s = 5'd3;
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL bp_hold_count%0d: got %0d want 2", k, count); end
         n_checks++; if (out_s !== 5'd1) begin n_fail++; $display("FAIL bp_stable%0d: out_s got %0d want 1", k, out_s); end
      end
      // Full and drained together: the pop must not open the door in the same cycle.
      out_ready = 1'b1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_passthru: in_ready got %b want 0", in_ready); end
      exp_s = exp_q.pop_front();
      n_checks++; if (out_s !== exp_s) begin n_fail++; $display("FAIL bp_drain_a: out_s got %0d want %0d", out_s, exp_s); end
      step();
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL bp_after_pop: count got %0d want 1", count); end
      exp_s = exp_q.pop_front();
      n_checks++; if (out_s !== exp_s) begin n_fail++; $display("FAIL bp_drain_b: out_s got %0d want %0d", out_s, exp_s); end
      step(); exp_q.push_back(5'd3);
      in_valid = 1'b0;
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL bp_push_pop: count got %0d want 1", count); end
      exp_s = exp_q.pop_front();
      n_checks++; if (out_s !== exp_s) begin n_fail++; $display("FAIL bp_drain_c: out_s got %0d want %0d", out_s, exp_s); end
      step();
      n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL bp_empty: out_valid=%b count=%0d want 0/0", out_valid, count); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      set_inputs(1'b0, 1'b0, 1'b0, 5'd5, 1'b0);
      in_valid = 1'b1;
      step();
      out_ready = 1'b1;
      in_s = 5'd6;
      n_checks++; if (out_s !== 5'd5) begin n_fail++; $display("FAIL b2b_head: out_s got %0d want 5", out_s); end
      step();
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count: got %0d want 1", count); end
      n_checks++; if (out_s !== 5'd6) begin n_fail++; $display("FAIL b2b_next: out_s got %0d want 6", out_s); end
      in_s = 5'd7;
      step();
      in_valid = 1'b0;
      n_checks++; if (out_s !== 5'd7 || count !== 2'd1) begin n_fail++; $display("FAIL b2b_third: out_s=%0d count=%0d want 7/1", out_s, count); end
      step();
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL b2b_empty: count got %0d want 0", count); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      set_inputs(1'b0, 1'b0, 1'b0, 5'd9, 1'b0);
      in_valid = 1'b1;
      step();
      in_s = 5'd10;
      step();
      in_valid = 1'b0;
      n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL rm_full: count got %0d want 2", count); end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async_valid: got %b want 0", out_valid); end
      n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL rm_async_count: got %0d want 0", count); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_output%0d: out_valid got %b want 0", k, out_valid); end
      end
      n_checks++; if (out_s !== 5'd0 || out_flags !== 4'd0) begin n_fail++; $display("FAIL rm_cleared: out_s=%b flags=%b want 0", out_s, out_flags); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_flags();
      test_back_pressure();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
- Registered, buffered result stage directly downstream of the 5-bit ripple add/subtract unit.
- Each cycle it accepts that unit's sum/carry together with the operation mode and operand sign bits.
- For each accepted result it computes N/Z/C/V flags and stores result plus flags in a 2-entry FIFO.
- Presents results to the consumer over a valid/ready handshake and back-pressures the producer when full.

Parameters:
- WIDTH, 5, datapath width; must match the add/sub unit.
- DEPTH, 2, FIFO entries; fixed at 2 (pointers are 1 bit).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a result this cycle.
- in_ready  output  1  stage can accept; equals (count != DEPTH).
- in_sub  input  1  1 = subtract, 0 = add (the mode the add/sub unit ran with).
- in_a_msb  input  1  MSB of operand A.
- in_b_msb  input  1  MSB of operand B, before inversion.
- in_s  input  WIDTH  sum from the add/sub unit.
- in_c  input  1  carry-out from the add/sub unit.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry.
- out_s  output  WIDTH  head entry result.
- out_flags  output  4  head entry flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- count  output  2  occupancy, 0..2.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - count=0, wr_ptr=rd_ptr=0, all storage cleared.
  - out_valid=0, out_s=0, out_flags=0, in_ready=1.
- Push: in_valid && in_ready at a clock edge. Writes {s, flags} at wr_ptr, toggles wr_ptr.
- Pop: out_valid && out_ready at a clock edge. Toggles rd_ptr.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: 1 cycle from accepted input to out_valid. No combinational bypass when empty.
- Output stability: while out_valid && !out_ready, out_s and out_flags hold stable.
- Full (count=2): in_ready=0 even if out_ready=1 in the same cycle (no pass-through). The producer must hold its inputs.
- Empty: out_valid=0. out_s/out_flags show the storage at rd_ptr and are don't-care to the consumer.
- Flag generation (combinational, on the value to be stored):
  - N = s[WIDTH-1].
  - Z = (s == 0).
  - C = in_c, raw. On subtract, 1 means no borrow.
  - V (add) = (a_msb == b_msb) && (in_s[WIDTH-1] != a_msb).
  - V (sub) = (a_msb != b_msb) && (in_s[WIDTH-1] != a_msb).
- Arithmetic: results wrap modulo 2^WIDTH; the stage never modifies in_s except as described under the optional feature.
- Reset mid-operation: all buffered entries are discarded; no partial output.

Optional Feature:
- Macro: ADDSUB_RESULT_SAT_EN.
- Defined: when V=1, the stored s is clamped to signed saturation: a_msb=0 gives 0_1111; a_msb=1 gives 1_0000.
  - V and C still reflect the raw operation.
  - N and Z are computed on the clamped value.
- Undefined: s is stored as received (wrap-around); no clamp logic is present.

Decomposition:
- Shared package/include addsub_pkg holds:
  - ADDSUB_WIDTH = 5.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FLAGS_W = 4.
- One combinational sub-module, addsub_flag_gen: inputs in_sub, a_msb, b_msb, in_s, in_c; outputs the stored s (saturated when enabled) and the 4 flags.
- FIFO control and storage live in the top module.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, then release -> out_valid=0, count=0, in_ready=1, out_s=0, out_flags=0.
- Add overflow 7+9: in_sub=0, a_msb=0, b_msb=0, in_s=5'b10000, in_c=0, out_ready=1 -> next cycle out_s=10000, flags=1001.
  - With ADDSUB_RESULT_SAT_EN: out_s=01111, flags=0001.
- Subtract 3-3: in_sub=1, a_msb=0, b_msb=0, in_s=0, in_c=1 -> out_s=0, flags=0110.
- Back-pressure: out_ready=0, offer 3 results (1, 2, 3) on consecutive cycles ->
  - in_ready drops after the 2nd is accepted; count=2; the 3rd is held by the producer.
  - Raising out_ready drains 1, then 2, then 3 in order.
  - out_s stays stable while stalled.
- Simultaneous push/pop at count=1 -> count stays 1; output order preserved.
- Reset asserted with count=2 -> same cycle out_valid=0, count=0, and the buffered entries are never output.
